// File: rtl/fec_frame_sched.sv
// fec_frame_sched: FWFT input FIFO plus PRIME/DATA/PARITY slot sequencer feeding fec_gen,
// with output flags delayed one extra stage to line up with fec_gen.dout.
module fec_frame_sched #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] IDLE_WORD = 32'h0707_0707
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        enable,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] fec_din,
  output logic        fec_parity_sel,
  output logic        out_valid,
  output logic        out_frame_start,
  output logic        out_parity,
  output logic        underflow,
  output logic [15:0] frame_count,
  output logic [15:0] underflow_count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, PRIME, DATA, PARITY} state_t;
  state_t state_q, state_d;
  logic [6:0] idx_q, idx_d;
  logic [31:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [31:0] fec_din_q, fec_din_d;
  logic psel_q, psel_d, uf_q, uf_d;
  logic v1_q, v1_d, fs1_q, fs1_d, par1_q, par1_d;
  logic ov_q, ofs_q, opar_q;
  logic [15:0] fc_q, fc_d, uc_q, uc_d;
  logic full, empty, wr, rd;
  always_comb begin
    full  = cnt_q == (AW+1)'(DEPTH);
    empty = cnt_q == '0;
    wr    = in_valid && !full;
    rd    = state_q == DATA && !empty;
    wr_d  = wr_q + AW'(wr);
    rd_d  = rd_q + AW'(rd);
    cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
  end
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    fec_din_d = '0;
    psel_d    = 1'b0;
    uf_d      = 1'b0;
    v1_d      = 1'b0;
    fs1_d     = 1'b0;
    par1_d    = 1'b0;
    case (state_q)
      IDLE: begin
        idx_d   = '0;
        state_d = enable ? PRIME : IDLE;
      end
      PRIME: begin
        psel_d  = 1'b1;
        idx_d   = '0;
        state_d = DATA;
      end
      DATA: begin
        fec_din_d = empty ? IDLE_WORD : mem_q[rd_q];
        uf_d      = empty;
        v1_d      = 1'b1;
        fs1_d     = idx_q == 7'd0;
        state_d   = idx_q == 7'd64 ? PARITY : DATA;
        idx_d     = idx_q == 7'd64 ? idx_q : idx_q + 7'd1;
      end
      PARITY: begin
        psel_d  = 1'b1;
        v1_d    = 1'b1;
        par1_d  = 1'b1;
        idx_d   = '0;
        state_d = enable ? DATA : IDLE;
      end
      default: state_d = IDLE;
    endcase
    fc_d = fc_q + 16'(state_q == PARITY);
    uc_d = (uf_d && uc_q != 16'hFFFF) ? uc_q + 16'd1 : uc_q;
  end
  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk)
    if (wr) mem_q[wr_q] <= in_data;
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      fec_din_q <= '0;
      psel_q    <= 1'b0;
      uf_q      <= 1'b0;
      v1_q      <= 1'b0;
      fs1_q     <= 1'b0;
      par1_q    <= 1'b0;
      ov_q      <= 1'b0;
      ofs_q     <= 1'b0;
      opar_q    <= 1'b0;
      fc_q      <= '0;
      uc_q      <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      fec_din_q <= fec_din_d;
      psel_q    <= psel_d;
      uf_q      <= uf_d;
      v1_q      <= v1_d;
      fs1_q     <= fs1_d;
      par1_q    <= par1_d;
      ov_q      <= v1_q;
      ofs_q     <= fs1_q;
      opar_q    <= par1_q;
      fc_q      <= fc_d;
      uc_q      <= uc_d;
    end
  end
  assign in_ready        = !full;
  assign fec_din         = fec_din_q;
  assign fec_parity_sel  = psel_q;
  assign out_valid       = ov_q;
  assign out_frame_start = ofs_q;
  assign out_parity      = opar_q;
  assign underflow       = uf_q;
  assign frame_count     = fc_q;
  assign underflow_count = uc_q;
endmodule

// File: tb/tb_fec_frame_sched.sv
// tb_fec_frame_sched: directed phases with randomized source traffic, checked every cycle
// against a slot-number/queue reference model of the frame schedule.
module tb_fec_frame_sched;
  localparam int DEPTH = 4;
  localparam logic [31:0] IDLE_W = 32'h0707_0707;
  logic clk = 1'b0, arst_n = 1'b0, enable = 1'b0, in_valid = 1'b0;
  logic [31:0] in_data = 32'd1;
  logic in_ready, fec_parity_sel, out_valid, out_frame_start, out_parity, underflow;
  logic [31:0] fec_din;
  logic [15:0] frame_count, underflow_count;
  int checks = 0, failures = 0;
  fec_frame_sched #(.DEPTH(DEPTH), .IDLE_WORD(IDLE_W)) dut (
    .clk(clk), .arst_n(arst_n), .enable(enable), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .fec_din(fec_din), .fec_parity_sel(fec_parity_sel),
    .out_valid(out_valid), .out_frame_start(out_frame_start), .out_parity(out_parity),
    .underflow(underflow), .frame_count(frame_count), .underflow_count(underflow_count)
  );
  always #5 clk = ~clk;
  // Reference: slot number since the last start (0 = prime, then 65 data + 1 parity per frame).
  logic [31:0] q[$];
  int mslot = -1, ph;
  logic [31:0] e_din = 0;
  logic e_psel = 0, e_uf = 0, v1 = 0, f1 = 0, p1 = 0, e_ov = 0, e_fs = 0, e_par = 0, m_took = 0;
  logic [15:0] e_fc = 0, e_uc = 0;
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      q.delete(); mslot = -1; e_din = 0; e_psel = 0; e_uf = 0;
      v1 = 0; f1 = 0; p1 = 0; e_ov = 0; e_fs = 0; e_par = 0; e_fc = 0; e_uc = 0; m_took = 0;
    end else begin
      e_ov = v1; e_fs = f1; e_par = p1;
      m_took = in_valid && (q.size() < DEPTH);
      e_din = 0; e_psel = 0; e_uf = 0; v1 = 0; f1 = 0; p1 = 0;
      ph = (mslot >= 1) ? (mslot - 1) % 66 : -1;
      if (mslot == 0) e_psel = 1;
      else if (ph >= 0 && ph < 65) begin
        v1 = 1; f1 = (ph == 0);
        if (q.size() > 0) e_din = q.pop_front();
        else begin
          e_din = IDLE_W; e_uf = 1;
          if (e_uc != 16'hFFFF) e_uc = e_uc + 16'd1;
        end
      end else if (ph == 65) begin
        e_psel = 1; v1 = 1; p1 = 1; e_fc = e_fc + 16'd1;
      end
      if (m_took) q.push_back(in_data);
      mslot = (mslot < 0) ? (enable ? 0 : -1) : (ph == 65 && !enable) ? -1 : mslot + 1;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    chk("fec_din", fec_din, e_din);
    chk("parity_sel", 32'(fec_parity_sel), 32'(e_psel));
    chk("underflow", 32'(underflow), 32'(e_uf));
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    chk("frame_start", 32'(out_frame_start), 32'(e_fs));
    chk("out_parity", 32'(out_parity), 32'(e_par));
    chk("frame_count", 32'(frame_count), 32'(e_fc));
    chk("uf_count", 32'(underflow_count), 32'(e_uc));
  endtask
  int mode = 0;
  task automatic drive();
    case (mode)
      0: begin if (m_took) in_data = in_data + 32'd1; in_valid = 1'b1; end
      1: in_valid = 1'b0;
      default: begin if (m_took) in_data = $urandom; in_valid = ($urandom_range(3) != 0); end
    endcase
  endtask
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); @(negedge clk);
      check_all();
      drive();
    end
  endtask
  function automatic bit at_idx(input int k);
    return mslot >= 1 && (mslot - 1) % 66 == k;
  endfunction
  task automatic wait_idx(input int k, input string tag);
    int n = 0;
    while (!at_idx(k) && n < 300) begin step(1); n++; end
    chk(tag, 32'(at_idx(k)), 32'd1);
  endtask
  initial begin
    #1;
    chk("rst_din", fec_din, 32'd0);
    chk("rst_psel", 32'(fec_parity_sel), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_fc", 32'(frame_count), 32'd0);
    chk("rst_uc", 32'(underflow_count), 32'd0);
    @(negedge clk); arst_n = 1'b1; in_valid = 1'b1;
    step(3);
    enable = 1'b1;
    step(220);
    wait_idx(20, "reach_stall");
    mode = 1; step(10); mode = 0;
    step(150);
    mode = 2; step(66 * 30);
    mode = 0; step(5);
    wait_idx(10, "reach_idx10");
    enable = 1'b0; step(80);
    chk("idle_after_drop", 32'(mslot), 32'hFFFF_FFFF);
    enable = 1'b1; step(100);
    wait_idx(30, "reach_idx30");
    #2 arst_n = 1'b0;
    #1 check_all();
    chk("mid_rst_fc", 32'(frame_count), 32'd0);
    chk("mid_rst_din", fec_din, 32'd0);
    @(negedge clk); check_all();
    arst_n = 1'b1;
    step(140);
    mode = 1; step(66 * 1010);
    chk("uf_saturated", 32'(underflow_count), 32'h0000_FFFF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
